// File: rtl/sha2_pkg.sv
// Shared SHA-2 round helpers: rotation amounts, Ch/Maj/Sigma functions, state packing.
// Functions work on 64-bit containers; for 32-bit words only the low half is meaningful.
package sha2_pkg;

    localparam int BS0_32 [3] = '{2, 13, 22};
    localparam int BS1_32 [3] = '{6, 11, 25};
    localparam int BS0_64 [3] = '{28, 34, 39};
    localparam int BS1_64 [3] = '{14, 18, 41};

    function automatic logic [63:0] word_mask(input int w);
        return (w == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        logic [63:0] xm;
        xm = x & word_mask(w);
        return ((xm >> n) | (xm << (w - n))) & word_mask(w);
    endfunction

    function automatic logic [63:0] ch(input logic [63:0] x, input logic [63:0] y,
                                       input logic [63:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [63:0] maj(input logic [63:0] x, input logic [63:0] y,
                                        input logic [63:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [63:0] big_sigma0(input logic [63:0] x, input int w);
        if (w == 64)
            return rotr(x, BS0_64[0], w) ^ rotr(x, BS0_64[1], w) ^ rotr(x, BS0_64[2], w);
        return rotr(x, BS0_32[0], w) ^ rotr(x, BS0_32[1], w) ^ rotr(x, BS0_32[2], w);
    endfunction

    function automatic logic [63:0] big_sigma1(input logic [63:0] x, input int w);
        if (w == 64)
            return rotr(x, BS1_64[0], w) ^ rotr(x, BS1_64[1], w) ^ rotr(x, BS1_64[2], w);
        return rotr(x, BS1_32[0], w) ^ rotr(x, BS1_32[1], w) ^ rotr(x, BS1_32[2], w);
    endfunction

    // Word index 0 is a (MSBs), 7 is h (LSBs).
    function automatic int word_lsb(input int idx, input int w);
        return (7 - idx) * w;
    endfunction

endpackage

// File: rtl/sha2_round_stage1.sv
// First pipeline stage of the SHA-2 round: computes T1/T2 and registers them with a..g.
module sha2_round_stage1
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [8*WORD_W-1:0]   state_in,
    input  logic [WORD_W-1:0]     k_in,
    input  logic [WORD_W-1:0]     w_in,
    output logic [WORD_W-1:0]     t1_q,
    output logic [WORD_W-1:0]     t2_q,
    output logic [7*WORD_W-1:0]   abcdefg_q
);

    logic [WORD_W-1:0]   word [8];
    logic [WORD_W-1:0]   t1_calc, t2_calc;
    logic [WORD_W-1:0]   t1_d, t2_d;
    logic [7*WORD_W-1:0] abcdefg_d;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
            assign word[gi] = state_in[word_lsb(gi, WORD_W) +: WORD_W];
        end
    endgenerate

    always_comb begin
        t1_calc = word[7]
                + WORD_W'(big_sigma1(64'(word[4]), WORD_W))
                + WORD_W'(ch(64'(word[4]), 64'(word[5]), 64'(word[6])))
                + k_in + w_in;
        t2_calc = WORD_W'(big_sigma0(64'(word[0]), WORD_W))
                + WORD_W'(maj(64'(word[0]), 64'(word[1]), 64'(word[2])));
        t1_d      = t1_q;
        t2_d      = t2_q;
        abcdefg_d = abcdefg_q;
        if (load) begin
            t1_d      = t1_calc;
            t2_d      = t2_calc;
            abcdefg_d = state_in[8*WORD_W-1:WORD_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t1_q      <= '0;
            t2_q      <= '0;
            abcdefg_q <= '0;
        end else begin
            t1_q      <= t1_d;
            t2_q      <= t2_d;
            abcdefg_q <= abcdefg_d;
        end
    end

endmodule

// File: rtl/sha2_round_pipe.sv
// Two-stage elastic SHA-2 compression round (WORD_W 32 or 64).
// Define SHA2_ROUND_CNT_EN to add the rounds_done output-handshake counter.
module sha2_round_pipe
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*WORD_W-1:0]   state_in,
    input  logic [WORD_W-1:0]     k_in,
    input  logic [WORD_W-1:0]     w_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*WORD_W-1:0]   state_out
`ifdef SHA2_ROUND_CNT_EN
    ,
    output logic [31:0]           rounds_done
`endif
);

    generate
        if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
            $error("sha2_round_pipe: WORD_W must be 32 or 64");
        end
    endgenerate

    logic                s1_valid_q, s1_valid_d;
    logic                s2_valid_q, s2_valid_d;
    logic                s2_accept, s1_advance, in_fire, out_fire;
    logic [WORD_W-1:0]   t1_q, t2_q;
    logic [7*WORD_W-1:0] abcdefg_q;
    logic [8*WORD_W-1:0] state_q, state_d;

    sha2_round_stage1 #(.WORD_W(WORD_W)) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .load      (in_fire),
        .state_in  (state_in),
        .k_in      (k_in),
        .w_in      (w_in),
        .t1_q      (t1_q),
        .t2_q      (t2_q),
        .abcdefg_q (abcdefg_q)
    );

    always_comb begin
        s2_accept  = !s2_valid_q || out_ready;
        s1_advance = s1_valid_q && s2_accept;
        in_ready   = !s1_valid_q || s1_advance;
        in_fire    = in_valid && in_ready;
        out_fire   = s2_valid_q && out_ready;
        s1_valid_d = in_fire || (s1_valid_q && !s1_advance);
        s2_valid_d = s1_advance || (s2_valid_q && !out_fire);
        state_d    = state_q;
        // abcdefg_q holds {a,b,c,d,e,f,g}: b'..d' take a..c, f'..h' take e..g.
        if (s1_advance)
            state_d = {t1_q + t2_q,
                       abcdefg_q[7*WORD_W-1:4*WORD_W],
                       abcdefg_q[4*WORD_W-1:3*WORD_W] + t1_q,
                       abcdefg_q[3*WORD_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            state_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            state_q    <= state_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign state_out = state_q;

`ifdef SHA2_ROUND_CNT_EN
    logic [31:0] rounds_done_q, rounds_done_d;

    always_comb begin
        rounds_done_d = rounds_done_q;
        if (out_fire)
            rounds_done_d = rounds_done_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rounds_done_q <= '0;
        else
            rounds_done_q <= rounds_done_d;
    end

    assign rounds_done = rounds_done_q;
`endif

endmodule
